// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg -- shared constants for the UART-to-memory bridge.
//   * Command opcodes ('W', 'R', 'G') and reply bytes (ACK, NAK).
//   * state_t: FSM state type, with the state codes as plain localparams so
//     older tools that dislike enums in packages still accept it.
package uart_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_GO    = 8'h47;
    localparam logic [7:0] BYTE_ACK = 8'h06;
    localparam logic [7:0] BYTE_NAK = 8'h15;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_ADDR      = 3'd1;
    localparam state_t S_DATA      = 3'd2;
    localparam state_t S_WRITE     = 3'd3;
    localparam state_t S_READ      = 3'd4;
    localparam state_t S_READ_WAIT = 3'd5;
    localparam state_t S_SEND      = 3'd6;
    localparam state_t S_SEND_WAIT = 3'd7;

endpackage

// File: rtl/uart_bridge_resp.sv
// uart_bridge_resp -- reply serializer for the UART-to-memory bridge.
// Holds a 1-to-4-byte reply queue and runs the tx_en/tx_done handshake,
// sending bytes LSB first.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load_i       start a reply (only honoured while idle)
//   bytes_i      reply bytes, byte 0 sent first
//   cnt_i        number of bytes to send (1..4)
//   tx_done_i    transmitter finished the current byte
//   tx_en_o      one-cycle start pulse to the transmitter
//   tx_data_o    byte being sent, held from tx_en_o until tx_done_i
//   more_o       bytes remain after the one currently on the line
module uart_bridge_resp
    import uart_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] bytes_i,
    input  logic [2:0]  cnt_i,
    input  logic        tx_done_i,
    output logic        tx_en_o,
    output logic [7:0]  tx_data_o,
    output logic        more_o
);

    state_t      phase_q;
    logic        tx_en_q;
    logic [7:0]  tx_data_q;
    logic [23:0] queue_q;
    logic [2:0]  left_q;

    // tx_en is raised on the edge that enters SEND, so the pulse coincides
    // with the SEND cycle and no extra latency is added to the reply.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= S_IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'hFF;
            queue_q   <= 24'h0;
            left_q    <= 3'd0;
        end else begin
            tx_en_q <= 1'b0;
            case (phase_q)
                S_IDLE: begin
                    if (load_i) begin
                        tx_en_q   <= 1'b1;
                        tx_data_q <= bytes_i[7:0];
                        queue_q   <= bytes_i[31:8];
                        left_q    <= cnt_i - 3'd1;
                        phase_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    phase_q <= S_SEND_WAIT;
                end
                S_SEND_WAIT: begin
                    if (tx_done_i) begin
                        if (left_q != 3'd0) begin
                            tx_en_q   <= 1'b1;
                            tx_data_q <= queue_q[7:0];
                            queue_q   <= {8'h00, queue_q[23:8]};
                            left_q    <= left_q - 3'd1;
                            phase_q   <= S_SEND;
                        end else begin
                            phase_q <= S_IDLE;
                        end
                    end
                end
                default: phase_q <= S_IDLE;
            endcase
        end
    end

    assign tx_en_o   = tx_en_q;
    assign tx_data_o = tx_data_q;
    assign more_o    = (left_q != 3'd0);

endmodule

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge -- byte-command bridge from a UART receiver to a 32-bit
// word memory, with a CPU hold line released by the 'G' command.
// Commands (little-endian operands):
//   'W' a0 a1 a2 a3 d0 d1 d2 d3  -> word write, reply ACK
//   'R' a0 a1 a2 a3              -> word read, reply 4 data bytes LSB first
//   'G'                          -> release cpu_hold, reply ACK
//   anything else                -> reply NAK
// Optional build macro UART_BRIDGE_TIMEOUT_EN: abandon a partial command
// after CLK_FREQ/1000*TIMEOUT_MS idle cycles and reply NAK.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rx_ready, rx_data    received byte strobe and data
//   tx_en, tx_data       transmit start pulse and byte
//   tx_done              transmitter stop bit finished
//   mem_we, mem_re       one-cycle write/read strobes
//   mem_addr, mem_wdata  word-aligned address and write data
//   mem_rdata            read data, valid one cycle after mem_re
//   cpu_hold             holds the CPU in reset until 'G'
module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int TIMEOUT_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        cpu_hold
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic        hold_q, hold_d;

    logic        resp_load;
    logic [31:0] resp_bytes;
    logic [2:0]  resp_cnt;
    logic        resp_more;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TMO_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;

    // Counts idle cycles while an operand is being collected.
    always_ff @(posedge clk) begin
        if (rst || rx_ready || !(state_q == S_ADDR || state_q == S_DATA)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (tmo_q == TMO_W'(TMO_CYCLES - 1));
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        resp_load  = 1'b0;
        resp_bytes = {24'h0, BYTE_NAK};
        resp_cnt   = 3'd1;

        case (state_q)
            S_IDLE: begin
                idx_d = 2'd0;
                if (rx_ready) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_write_d = (rx_data == OP_WRITE);
                        state_d    = S_ADDR;
                    end else begin
                        if (rx_data == OP_GO) begin
                            hold_d     = 1'b0;
                            resp_bytes = {24'h0, BYTE_ACK};
                        end
                        resp_load = 1'b1;
                        state_d   = S_SEND;
                    end
                end
            end
            S_ADDR: begin
                if (rx_ready) begin
                    addr_d[{idx_q, 3'b000} +: 8] = rx_data;
                    // Word alignment is applied at capture time.
                    addr_d[1:0] = 2'b00;
                    idx_d       = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (is_write_q) begin
                            state_d = S_DATA;
                        end else begin
                            mem_re_d = 1'b1;
                            state_d  = S_READ;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_ready) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        mem_we_d = 1'b1;
                        state_d  = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                resp_load  = 1'b1;
                resp_bytes = {24'h0, BYTE_ACK};
                state_d    = S_SEND;
            end
            S_READ: begin
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                // mem_rdata is valid in this cycle; the serializer captures it.
                resp_load  = 1'b1;
                resp_bytes = mem_rdata;
                resp_cnt   = 3'd4;
                state_d    = S_SEND;
            end
            S_SEND: begin
                state_d = S_SEND_WAIT;
            end
            S_SEND_WAIT: begin
                if (tx_done) begin
                    state_d = resp_more ? S_SEND : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_BRIDGE_TIMEOUT_EN
        if ((state_q == S_ADDR || state_q == S_DATA) && !rx_ready && tmo_hit) begin
            idx_d      = 2'd0;
            resp_load  = 1'b1;
            resp_bytes = {24'h0, BYTE_NAK};
            resp_cnt   = 3'd1;
            state_d    = S_SEND;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            is_write_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            hold_q     <= hold_d;
        end
    end

    uart_bridge_resp u_resp (
        .clk       (clk),
        .rst       (rst),
        .load_i    (resp_load),
        .bytes_i   (resp_bytes),
        .cnt_i     (resp_cnt),
        .tx_done_i (tx_done),
        .tx_en_o   (tx_en),
        .tx_data_o (tx_data),
        .more_o    (resp_more)
    );

    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge -- self-checking bench for uart_mem_bridge.
// Directed and random commands are sent byte by byte; a command-level
// reference model predicts memory strobes, reply bytes and cpu_hold.
module tb_uart_mem_bridge;

    localparam int CLK_FREQ   = 100_000;
    localparam int TIMEOUT_MS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        cpu_hold;

    uart_mem_bridge #(
        .CLK_FREQ   (CLK_FREQ),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory device and transmitter model ----------------
    function automatic logic [31:0] fill(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    int          we_cnt, re_cnt, hs_err;
    int          rx_cyc, we_cyc, tx_first_cyc;
    logic [31:0] we_addr_q[$], we_data_q[$], re_addr_q[$];
    logic [7:0]  tx_q[$];
    bit          tx_busy = 0;
    logic [7:0]  tx_hold;
    int          tx_timer;
    bit          rd_arm = 0;
    logic [31:0] rd_addr;

    always @(negedge clk) begin
        if (rx_ready) rx_cyc = cyc;
        if (mem_we) begin
            if (we_cnt == 0) we_cyc = cyc;
            we_cnt++;
            we_addr_q.push_back(mem_addr);
            we_data_q.push_back(mem_wdata);
            dev_mem[mem_addr] = mem_wdata;
        end
        if (mem_re) begin
            re_cnt++;
            re_addr_q.push_back(mem_addr);
            rd_arm  = 1;
            rd_addr = mem_addr;
        end
        if (tx_en) begin
            if (tx_busy) hs_err++;
            if (tx_q.size() == 0) tx_first_cyc = cyc;
            tx_q.push_back(tx_data);
            tx_busy  = 1;
            tx_hold  = tx_data;
            tx_timer = $urandom_range(1, 6);
        end else if (tx_busy && tx_data !== tx_hold) begin
            hs_err++;
        end
    end

    always @(posedge clk) begin
        #1;
        tx_done = 1'b0;
        if (tx_busy) begin
            if (tx_timer == 0) begin
                tx_done = 1'b1;
                tx_busy = 0;
            end else begin
                tx_timer--;
            end
        end
        if (rd_arm) begin
            mem_rdata = dev_mem.exists(rd_addr) ? dev_mem[rd_addr] : fill(rd_addr);
            rd_arm    = 0;
        end else begin
            mem_rdata = $urandom;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  cmd_q[$];
    bit          ref_hold = 1;
    int          e_we, e_re;
    logic [31:0] e_addr, e_wdata;
    logic [7:0]  e_tx[$];

    task automatic model();
        logic [31:0] d;
        e_we = 0;
        e_re = 0;
        e_tx.delete();
        if (cmd_q[0] == 8'h57 || cmd_q[0] == 8'h52) begin
            // A truncated command only ends by timeout: discarded, NAK.
            if (cmd_q.size() < ((cmd_q[0] == 8'h57) ? 9 : 5)) begin
                e_tx.push_back(8'h15);
                return;
            end
            e_addr = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]} & 32'hFFFF_FFFC;
            if (cmd_q[0] == 8'h57) begin
                e_wdata         = {cmd_q[8], cmd_q[7], cmd_q[6], cmd_q[5]};
                ref_mem[e_addr] = e_wdata;
                e_we            = 1;
                e_tx.push_back(8'h06);
            end else begin
                d    = ref_mem.exists(e_addr) ? ref_mem[e_addr] : fill(e_addr);
                e_re = 1;
                for (int i = 0; i < 4; i++) e_tx.push_back(d[8*i +: 8]);
            end
        end else if (cmd_q[0] == 8'h47) begin
            ref_hold = 0;
            e_tx.push_back(8'h06);
        end else begin
            e_tx.push_back(8'h15);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_obs();
        we_cnt = 0;
        re_cnt = 0;
        hs_err = 0;
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
        tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic run_cmd(input string tag, input int split_at, input int split_gap);
        int budget;
        clear_obs();
        model();
        for (int i = 0; i < cmd_q.size(); i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_byte(cmd_q[i]);
            if (i == split_at) repeat (split_gap) @(posedge clk);
        end
        budget = 0;
        while ((tx_q.size() < e_tx.size() || tx_busy) && budget < 600) begin
            @(posedge clk);
            budget++;
        end
        check({tag, "/reply_in_time"}, budget < 600, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check({tag, "/we_count"}, we_cnt, e_we);
        if (e_we == 1 && we_cnt > 0) begin
            check({tag, "/we_addr"}, we_addr_q[0], e_addr);
            check({tag, "/we_data"}, we_data_q[0], e_wdata);
            check({tag, "/we_latency"}, we_cyc - rx_cyc, 1);
            check({tag, "/ack_latency"}, (tx_first_cyc - we_cyc >= 1) && (tx_first_cyc - we_cyc <= 3), 1'b1);
        end
        check({tag, "/re_count"}, re_cnt, e_re);
        if (e_re == 1 && re_cnt > 0) begin
            check({tag, "/re_addr"}, re_addr_q[0], e_addr);
            if (tx_q.size() > 0)
                check({tag, "/read_latency"}, (tx_first_cyc - rx_cyc >= 1) && (tx_first_cyc - rx_cyc <= 3), 1'b1);
        end
        check({tag, "/tx_count"}, tx_q.size(), e_tx.size());
        for (int i = 0; i < e_tx.size() && i < tx_q.size(); i++)
            check($sformatf("%s/tx_byte%0d", tag, i), tx_q[i], e_tx[i]);
        check({tag, "/handshake"}, hs_err, 0);
        check({tag, "/cpu_hold"}, cpu_hold, ref_hold);
        $display("txn %s: bytes=%0d we=%0d re=%0d tx=%0d hold=%0b", tag, cmd_q.size(), we_cnt, re_cnt, tx_q.size(), cpu_hold);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, d;
        logic [7:0]  op;
        dev_mem[32'h10] = 32'h11223344;
        ref_mem[32'h10] = 32'h11223344;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/tx_en", tx_en, 1'b0);
        check("reset/tx_data", tx_data, 8'hFF);
        check("reset/mem_we", mem_we, 1'b0);
        check("reset/mem_re", mem_re, 1'b0);
        check("reset/mem_addr", mem_addr, 32'h0);
        check("reset/mem_wdata", mem_wdata, 32'h0);
        check("reset/cpu_hold", cpu_hold, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        cmd_q = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
        run_cmd("read_11223344", -1, 0);
        cmd_q = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_cmd("write_deadbeef", -1, 0);
        cmd_q = '{8'h57, 8'h13, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run_cmd("write_unaligned", -1, 0);
        cmd_q = '{8'h47};
        run_cmd("go", -1, 0);
        cmd_q = '{8'h00};
        run_cmd("junk_nak", -1, 0);

        // Reset after the 3rd address byte: command abandoned, hold re-asserted.
        clear_obs();
        send_byte(8'h57);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ref_hold = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midreset/we_count", we_cnt, 0);
        check("midreset/re_count", re_cnt, 0);
        check("midreset/tx_count", tx_q.size(), 0);
        check("midreset/cpu_hold", cpu_hold, 1'b1);
        $display("txn midreset: we=%0d re=%0d tx=%0d hold=%0b", we_cnt, re_cnt, tx_q.size(), cpu_hold);
        cmd_q = '{8'h57, 8'h24, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        run_cmd("write_after_reset", -1, 0);

`ifdef UART_BRIDGE_TIMEOUT_EN
        cmd_q = '{8'h57, 8'h01};
        run_cmd("timeout_nak", -1, 0);
        cmd_q = '{8'h52, 8'h24, 8'h00, 8'h00, 8'h00};
        run_cmd("read_after_timeout", -1, 0);
`else
        cmd_q = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_cmd("long_gap_write", 1, 300);
        cmd_q = '{8'h52, 8'h30, 8'h00, 8'h00, 8'h00};
        run_cmd("read_after_gap", -1, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
            d = $urandom;
            if (kind <= 3) begin
                cmd_q = '{8'h57, a[7:0], a[15:8], a[23:16], a[31:24], d[7:0], d[15:8], d[23:16], d[31:24]};
            end else if (kind <= 7) begin
                cmd_q = '{8'h52, a[7:0], a[15:8], a[23:16], a[31:24]};
            end else if (kind == 8) begin
                cmd_q = '{8'h47};
            end else begin
                do op = 8'($urandom); while (op == 8'h57 || op == 8'h52 || op == 8'h47);
                cmd_q = '{op};
            end
            run_cmd($sformatf("rand%0d", n), -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
